guess_entry: RTL and testbench
==============================

Name: guess_entry

Overview:
- Keypad entry stage between the PS/2 keyboard decoder and the guessing-game judge.
- Turns decoder press events (key_valid, key_down, last_change) into an editable 2-digit BCD guess, with backspace, clear and Enter.
- On Enter, emits a one-cycle submit strobe carrying the binary guess value to the judge.
- Drives BCD nibbles the display chooser renders directly; 4'hB means a blank digit.

Parameters:
- SC_ENTER, 9'h05A, scan code that submits
- SC_BKSP, 9'h066, scan code that deletes the last digit
- SC_ESC, 9'h076, scan code that clears the buffer
- BLANK, 4'hB, nibble value for an empty digit position

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  entry enabled; judge holds high while it accepts guesses
- key_valid  in  1  one-cycle strobe from the keyboard decoder
- key_down  in  512  key held map from the keyboard decoder
- last_change  in  9  {extend, code} of the latest key event
- guess_bcd  out  8  {tens, ones} nibbles; BLANK marks empty positions
- digit_cnt  out  2  digits currently held, 0..2
- guess_dec  out  7  binary value, tens*10+ones; a BLANK nibble counts as 0
- submit  out  1  one-cycle pulse; guess_dec is valid in the same cycle
- entry_err  out  1  one-cycle pulse when Enter is pressed with 0 digits

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values, all outputs and state registers: guess_bcd=8'hBB, digit_cnt=0, guess_dec=0, submit=0, entry_err=0, state=OFF.
- Press event (press) = key_valid && key_down[last_change]. Events with key_valid and a released key are ignored.
- Typematic repeats of digit, backspace and escape keys count as new presses.
- Digit codes, extend bit 0: 0x70=0, 0x69=1, 0x72=2, 0x7A=3, 0x6B=4, 0x73=5, 0x74=6, 0x6C=7, 0x75=8, 0x7D=9.
- All outputs are registered. A press sampled in cycle N is visible in cycle N+1.
- FSM states: OFF, ENTRY, SUBMIT, WAIT_REL.
- OFF:
  - Buffer is held at 8'hBB, digit_cnt=0.
  - Goes to ENTRY on the cycle en is sampled high.
- ENTRY, digit press:
  - Buffer shifts left: {ones, d}.
  - digit_cnt saturates at 2. A third digit drops the oldest; the count stays 2.
- ENTRY, SC_BKSP press:
  - Buffer becomes {BLANK, tens}.
  - digit_cnt decrements with a floor of 0. Backspace with 0 digits changes nothing.
- ENTRY, SC_ESC press: buffer=8'hBB, digit_cnt=0.
- ENTRY, SC_ENTER press:
  - digit_cnt=0: entry_err=1 for one cycle; stay in ENTRY.
  - digit_cnt≥1: go to SUBMIT.
- ENTRY, any other code: ignored.
- SUBMIT, one cycle:
  - submit=1; guess_dec and guess_bcd hold the entered value.
  - Next cycle: buffer=8'hBB, digit_cnt=0, go to WAIT_REL.
- WAIT_REL:
  - All presses are ignored. This blocks Enter auto-repeat from double-submitting.
  - Goes to ENTRY when key_down[SC_ENTER]==0.
- guess_dec is computed combinationally from the buffer, then registered. Range is 0..99, no overflow.
- en low in any state: next cycle state=OFF, buffer cleared, submit and entry_err forced 0. This has priority over any simultaneous press.
- rst assertion mid-entry or mid-SUBMIT: immediate return to reset values; no submit pulse is emitted.
- submit and entry_err are never high in the same cycle.

Test Plan:
- Reset, en=1, press 4 then 7 → guess_bcd=8'h47, digit_cnt=2. Press Enter → submit=1 for exactly one cycle with guess_dec=47. Next cycle guess_bcd=8'hBB.
- Press 1, 2, 3 → guess_bcd=8'h23, digit_cnt=2. Press BKSP → 8'hB2, cnt=1. Press Enter → submit with guess_dec=2.
- Enter with empty buffer → entry_err pulses once, submit stays 0. BKSP on empty buffer → no change.
- Hold Enter with 5 repeated make events after submitting "9" → exactly one submit. Digit presses before the Enter release are ignored; after the release, a digit 3 press gives 8'hB3.
- Type 8, deassert en in the same cycle as a digit-5 press → OFF state, guess_bcd=8'hBB, no update. Reassert en → entry resumes from empty.
- Assert rst during SUBMIT → submit=0 immediately, all outputs at reset values. Release-only events (key_down bit 0) → no change.

Source files
------------

// File: rtl/guess_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : guess_entry
// Brief    : Keypad entry stage: edits a 2-digit BCD guess from key events
//            and strobes the binary value to the judge on Enter.
// Revision : 1.0 - initial release
// ============================================================================
module guess_entry #(
   parameter logic [8:0] SC_ENTER = 9'h05A,
   parameter logic [8:0] SC_BKSP  = 9'h066,
   parameter logic [8:0] SC_ESC   = 9'h076,
   parameter logic [3:0] BLANK    = 4'hB
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         key_valid,
   input  logic [511:0] key_down,
   input  logic [8:0]   last_change,
   output logic [7:0]   guess_bcd,
   output logic [1:0]   digit_cnt,
   output logic [6:0]   guess_dec,
   output logic         submit,
   output logic         entry_err
);

   localparam logic [7:0] C_EMPTY = {BLANK, BLANK};

   typedef enum logic [1:0] {
      OFF      = 2'd0,
      ENTRY    = 2'd1,
      SUBMIT   = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_buf, w_buf_nxt;
   logic [1:0] r_cnt, w_cnt_nxt;
   logic [6:0] r_dec, w_dec_nxt;
   logic       r_submit, w_submit_nxt;
   logic       r_err, w_err_nxt;
   logic       w_press;
   logic       w_is_digit;
   logic [3:0] w_digit;
   logic [6:0] w_tens, w_ones;

   assign w_press = key_valid && key_down[last_change];

   always_comb begin
      w_is_digit = 1'b1;
      w_digit    = 4'd0;
      case (last_change)
         9'h070:  w_digit = 4'd0;
         9'h069:  w_digit = 4'd1;
         9'h072:  w_digit = 4'd2;
         9'h07A:  w_digit = 4'd3;
         9'h06B:  w_digit = 4'd4;
         9'h073:  w_digit = 4'd5;
         9'h074:  w_digit = 4'd6;
         9'h06C:  w_digit = 4'd7;
         9'h075:  w_digit = 4'd8;
         9'h07D:  w_digit = 4'd9;
         default: w_is_digit = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_buf_nxt    = r_buf;
      w_cnt_nxt    = r_cnt;
      w_submit_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      if (!en) begin
         // Disable wins over any press arriving in the same cycle
         w_state_nxt = OFF;
         w_buf_nxt   = C_EMPTY;
         w_cnt_nxt   = 2'd0;
      end else begin
         case (r_state)
            OFF: begin
               w_state_nxt = ENTRY;
               w_buf_nxt   = C_EMPTY;
               w_cnt_nxt   = 2'd0;
            end
            ENTRY: begin
               if (w_press) begin
                  if (w_is_digit) begin
                     w_buf_nxt = {r_buf[3:0], w_digit};
                     w_cnt_nxt = (r_cnt == 2'd2) ? 2'd2 : r_cnt + 2'd1;
                  end else if (last_change == SC_BKSP) begin
                     if (r_cnt != 2'd0) begin
                        w_buf_nxt = {BLANK, r_buf[7:4]};
                        w_cnt_nxt = r_cnt - 2'd1;
                     end
                  end else if (last_change == SC_ESC) begin
                     w_buf_nxt = C_EMPTY;
                     w_cnt_nxt = 2'd0;
                  end else if (last_change == SC_ENTER) begin
                     if (r_cnt == 2'd0) begin
                        w_err_nxt = 1'b1;
                     end else begin
                        w_state_nxt  = SUBMIT;
                        w_submit_nxt = 1'b1;
                     end
                  end
               end
            end
            SUBMIT: begin
               w_state_nxt = WAIT_REL;
               w_buf_nxt   = C_EMPTY;
               w_cnt_nxt   = 2'd0;
            end
            WAIT_REL: begin
               // Held Enter keeps repeating; wait for its release before re-arming
               if (!key_down[SC_ENTER]) w_state_nxt = ENTRY;
            end
            default: w_state_nxt = OFF;
         endcase
      end
   end

   assign w_tens    = (w_buf_nxt[7:4] == BLANK) ? 7'd0 : {3'd0, w_buf_nxt[7:4]};
   assign w_ones    = (w_buf_nxt[3:0] == BLANK) ? 7'd0 : {3'd0, w_buf_nxt[3:0]};
   assign w_dec_nxt = w_tens * 7'd10 + w_ones;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= OFF;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf    <= C_EMPTY;
         r_cnt    <= 2'd0;
         r_dec    <= 7'd0;
         r_submit <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_buf    <= w_buf_nxt;
         r_cnt    <= w_cnt_nxt;
         r_dec    <= w_dec_nxt;
         r_submit <= w_submit_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign guess_bcd = r_buf;
   assign digit_cnt = r_cnt;
   assign guess_dec = r_dec;
   assign submit    = r_submit;
   assign entry_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_guess_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_guess_entry
// Brief    : Scoreboard bench for guess_entry with a digit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

   logic         clk = 1'b0;
   logic         rst, en, key_valid;
   logic [511:0] key_down;
   logic [8:0]   last_change;
   logic [7:0]   guess_bcd;
   logic [1:0]   digit_cnt;
   logic [6:0]   guess_dec;
   logic         submit, entry_err;

   guess_entry dut (
      .clk(clk), .rst(rst), .en(en), .key_valid(key_valid),
      .key_down(key_down), .last_change(last_change),
      .guess_bcd(guess_bcd), .digit_cnt(digit_cnt), .guess_dec(guess_dec),
      .submit(submit), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bcd; int cnt; int dec; int sub; int err;
   } exp_t;

   exp_t scb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: digits typed so far, oldest first
   int digits[$];
   int dmap[int];
   bit m_on, m_submitting, m_waitrel;

   localparam int ENTER = 9'h05A, BKSP = 9'h066, ESC = 9'h076;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t e;
      int   lc;
      bit   press;
      lc    = int'(last_change);
      press = key_valid && key_down[last_change];
      e.sub = 0;
      e.err = 0;
      if (!en) begin
         m_on = 0; m_submitting = 0; m_waitrel = 0; digits.delete();
      end else if (!m_on) begin
         m_on = 1;
      end else if (m_submitting) begin
         m_submitting = 0; m_waitrel = 1; digits.delete();
      end else if (m_waitrel) begin
         if (!key_down[ENTER]) m_waitrel = 0;
      end else if (press) begin
         if (dmap.exists(lc)) begin
            digits.push_back(dmap[lc]);
            if (digits.size() > 2) void'(digits.pop_front());
         end else if (lc == BKSP) begin
            if (digits.size() > 0) void'(digits.pop_back());
         end else if (lc == ESC) begin
            digits.delete();
         end else if (lc == ENTER) begin
            if (digits.size() == 0) e.err = 1;
            else begin m_submitting = 1; e.sub = 1; end
         end
      end
      e.cnt = digits.size();
      case (digits.size())
         0: begin e.bcd = 'hBB; e.dec = 0; end
         1: begin e.bcd = 'hB0 + digits[0]; e.dec = digits[0]; end
         default: begin
            e.bcd = digits[0] * 16 + digits[1];
            e.dec = digits[0] * 10 + digits[1];
         end
      endcase
      scb.push_back(e);
   endtask

   task automatic apply(input bit e, input bit v, input logic [8:0] code, input bit dn);
      en          = e;
      key_valid   = v;
      last_change = code;
      if (v) key_down[code] = dn;
      model_step();
   endtask

   task automatic drive(input bit e, input bit v, input logic [8:0] code, input bit dn);
      @(negedge clk);
      apply(e, v, code, dn);
   endtask

   task automatic key(input logic [8:0] code);
      drive(1, 1, code, 1);
   endtask

   task automatic rel(input logic [8:0] code);
      drive(1, 1, code, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 9'h000, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bcd"}, int'(guess_bcd), 'hBB);
      chk({tag, "_cnt"}, int'(digit_cnt), 0);
      chk({tag, "_dec"}, int'(guess_dec), 0);
      chk({tag, "_submit"}, int'(submit), 0);
      chk({tag, "_err"}, int'(entry_err), 0);
   endtask

   // Monitor: every clock edge the DUT presents a fresh registered state
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (scb.size() > 0) begin
         e = scb.pop_front();
         chk("guess_bcd", int'(guess_bcd), e.bcd);
         chk("digit_cnt", int'(digit_cnt), e.cnt);
         chk("guess_dec", int'(guess_dec), e.dec);
         chk("submit", int'(submit), e.sub);
         chk("entry_err", int'(entry_err), e.err);
         if (submit && entry_err) chk("sub_err_excl", 1, 0);
      end
   end

   initial begin
      logic [8:0] codes [16];
      dmap[9'h070] = 0; dmap[9'h069] = 1; dmap[9'h072] = 2; dmap[9'h07A] = 3;
      dmap[9'h06B] = 4; dmap[9'h073] = 5; dmap[9'h074] = 6; dmap[9'h06C] = 7;
      dmap[9'h075] = 8; dmap[9'h07D] = 9;
      codes = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074, 9'h06C,
                9'h075, 9'h07D, 9'h066, 9'h076, 9'h05A, 9'h05A, 9'h170, 9'h01C};
      rst = 1'b0; en = 1'b0; key_valid = 1'b0; key_down = '0; last_change = '0;
      #1 rst = 1'b1;
      #2 chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;
      apply(0, 0, 9'h000, 0);
      idle(2);

      // 4, 7, Enter -> 47
      key(9'h06B); key(9'h06C); idle(1); key(ENTER); idle(3); rel(ENTER); idle(1);
      // 1, 2, 3, backspace, Enter -> 2
      key(9'h069); key(9'h072); key(9'h07A); key(BKSP); idle(1); key(ENTER);
      idle(2); rel(ENTER); idle(1);
      // Empty Enter and empty backspace
      key(ENTER); rel(ENTER); key(BKSP); idle(2);
      // Held Enter after "9": repeats and digits ignored until release
      key(9'h07D); key(ENTER);
      for (int i = 0; i < 5; i++) begin key(ENTER); key(9'h069); end
      rel(ENTER); key(9'h07A); idle(2);
      // Disable in same cycle as digit press, then resume
      key(ESC); key(9'h075); drive(0, 1, 9'h073, 1); drive(0, 0, 9'h000, 0);
      idle(2); key(9'h073); idle(1);
      // Release-only events change nothing
      rel(9'h073); rel(9'h069); idle(1);
      // Async reset while submit is high
      key(ESC); key(9'h073); key(ENTER);
      @(posedge clk); #4;
      rst = 1'b1;
      #1 chk_reset_vals("rst_mid_submit");
      m_on = 0; m_submitting = 0; m_waitrel = 0; digits.delete();
      @(negedge clk);
      rst = 1'b0;
      apply(1, 1, 9'h05A, 0);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 30) != 0, $urandom_range(0, 2) != 0,
               codes[$urandom_range(0, 15)], $urandom_range(0, 4) != 0);
      end
      idle(3);
      @(posedge clk); #3;
      if (scb.size() != 0) chk("scoreboard_drain", scb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
